// File: rtl/button_encoder.sv
// rtl/button_encoder.sv - push-button front end: sync, debounce, single-press encode, chord reject
module button_encoder #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] BTN,
  input  logic       ENABLE,
  output logic [1:0] IN,
  output logic       IN_VALID,
  output logic       MULTI_ERR,
  output logic [3:0] BTN_STABLE
);

  localparam int CW = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_REL = 2'd0,
    ARMED    = 2'd1,
    HELD     = 2'd2
  } state_t;

  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    stable_q;
  logic [CW-1:0] cnt [4];
  logic [1:0]    fill_q;
  state_t        state;
  logic [1:0]    in_q;
  logic          valid_q;
  logic          err_q;

  logic          any_set;
  logic          single_set;
  logic          multi_set;
  logic          settled;
  logic [1:0]    enc;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1  <= '0;
      sync2  <= '0;
      fill_q <= '0;
    end else begin
      sync1  <= BTN;
      sync2  <= sync1;
      fill_q <= {fill_q[0], 1'b1};
    end
  end

  // Counter only advances while the synchronised level disagrees with the accepted one
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stable_q <= '0;
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (sync2[k] == stable_q[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] == CNT_MAX) begin
          stable_q[k] <= sync2[k];
          cnt[k]      <= '0;
        end else begin
          cnt[k] <= cnt[k] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    any_set    = (stable_q != 4'b0000);
    single_set = any_set && ((stable_q & (stable_q - 4'd1)) == 4'b0000);
    multi_set  = any_set && !single_set;
    enc        = 2'd0;
    if (stable_q[1]) enc = 2'd1;
    if (stable_q[2]) enc = 2'd2;
    if (stable_q[3]) enc = 2'd3;
  end

  // A release only counts once the sync chain is primed and nothing is mid-debounce,
  // so a button held through reset cannot look released for the first few cycles.
  assign settled = fill_q[1] && (sync2 == stable_q);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= WAIT_REL;
      in_q    <= 2'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        WAIT_REL: begin
          if (!any_set && settled) state <= ARMED;
        end
        ARMED: begin
          if (multi_set) begin
            err_q <= 1'b1;
            state <= WAIT_REL;
          end else if (single_set) begin
            if (ENABLE) begin
              in_q    <= enc;
              valid_q <= 1'b1;
              state   <= HELD;
            end else begin
              state <= WAIT_REL;
            end
          end
        end
        HELD: begin
          if (!any_set) state <= ARMED;
        end
        default: state <= WAIT_REL;
      endcase
    end
  end

  assign IN         = in_q;
  assign IN_VALID   = valid_q;
  assign MULTI_ERR  = err_q;
  assign BTN_STABLE = stable_q;

endmodule

// File: tb/tb_button_encoder.sv
// tb/tb_button_encoder.sv - directed self-checking bench for button_encoder
module tb_button_encoder;

  logic       CLK;
  logic       RST_N;
  logic [3:0] BTN;
  logic       ENABLE;
  logic [1:0] IN;
  logic       IN_VALID;
  logic       MULTI_ERR;
  logic [3:0] BTN_STABLE;

  int         total;
  int         bad;
  int         n_valid;
  int         n_err;
  logic [1:0] last_in;
  logic [1:0] prev_in;

  button_encoder #(.DEBOUNCE_CYCLES(4)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .BTN        (BTN),
    .ENABLE     (ENABLE),
    .IN         (IN),
    .IN_VALID   (IN_VALID),
    .MULTI_ERR  (MULTI_ERR),
    .BTN_STABLE (BTN_STABLE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_valid = 0;
    n_err   = 0;
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      if (IN_VALID === 1'b1) begin
        n_valid++;
        last_in = IN;
      end
      if (MULTI_ERR === 1'b1) n_err++;
      check("valid_err_excl", {31'd0, IN_VALID & MULTI_ERR}, 32'd0);
      if (IN_VALID !== 1'b1) check("in_hold", {30'd0, IN}, {30'd0, prev_in});
      prev_in = IN;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    total   = 0;
    bad     = 0;
    last_in = 2'd0;
    prev_in = 2'd0;
    clear_counts();
    RST_N   = 1'b0;
    BTN     = 4'b0000;
    ENABLE  = 1'b1;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_in", {30'd0, IN}, 32'd0);
    check("rst_valid", {31'd0, IN_VALID}, 32'd0);
    check("rst_err", {31'd0, MULTI_ERR}, 32'd0);
    check("rst_stable", {28'd0, BTN_STABLE}, 32'd0);
    RST_N = 1'b1;
    run(5);

    // Clean press of colour 1: stable after edge 5, pulse between edges 6 and 7
    clear_counts();
    BTN = 4'b0010;
    run(5);
    check("t1_stable_e4", {28'd0, BTN_STABLE}, 32'h0);
    run(1);
    check("t1_stable_e5", {28'd0, BTN_STABLE}, 32'h2);
    check("t1_valid_e5", {31'd0, IN_VALID}, 32'd0);
    run(1);
    check("t1_valid_e6", {31'd0, IN_VALID}, 32'd1);
    check("t1_in_e6", {30'd0, IN}, 32'd1);
    run(1);
    check("t1_valid_e7", {31'd0, IN_VALID}, 32'd0);
    check("t1_in_e7", {30'd0, IN}, 32'd1);
    run(10);
    check("t1_one_pulse", n_valid, 32'd1);
    BTN = 4'b0000;
    run(12);

    // Bounce on colour 2
    clear_counts();
    BTN = 4'b0100; run(1);
    BTN = 4'b0000; run(1);
    BTN = 4'b0100; run(1);
    BTN = 4'b0000; run(1);
    check("t2_stable_bounce", {28'd0, BTN_STABLE}, 32'h0);
    BTN = 4'b0100;
    run(5);
    check("t2_stable_f4", {28'd0, BTN_STABLE}, 32'h0);
    check("t2_no_early_pulse", n_valid, 32'd0);
    run(1);
    check("t2_stable_f5", {28'd0, BTN_STABLE}, 32'h4);
    check("t2_valid_f5", {31'd0, IN_VALID}, 32'd0);
    run(1);
    check("t2_valid_f6", {31'd0, IN_VALID}, 32'd1);
    check("t2_in_f6", {30'd0, IN}, 32'd2);
    run(10);
    check("t2_one_pulse", n_valid, 32'd1);
    BTN = 4'b0000;
    run(12);

    // Hold, release, press again on colour 3
    clear_counts();
    BTN = 4'b1000; run(50);
    check("t3_hold_pulses", n_valid, 32'd1);
    BTN = 4'b0000; run(10);
    BTN = 4'b1000; run(12);
    check("t3_two_pulses", n_valid, 32'd2);
    check("t3_last_in", {30'd0, last_in}, 32'd3);
    BTN = 4'b0000;
    run(12);

    // Chord, then a clean colour-0 press
    clear_counts();
    BTN = 4'b0101; run(12);
    check("t4_chord_err", n_err, 32'd1);
    check("t4_chord_valid", n_valid, 32'd0);
    check("t4_chord_stable", {28'd0, BTN_STABLE}, 32'h5);
    BTN = 4'b0000; run(12);
    BTN = 4'b0001; run(12);
    check("t4_after_valid", n_valid, 32'd1);
    check("t4_after_in", {30'd0, last_in}, 32'd0);
    check("t4_after_err", n_err, 32'd1);
    BTN = 4'b0000;
    run(12);

    // ENABLE low during press, raised while still held
    clear_counts();
    ENABLE = 1'b0;
    BTN = 4'b0100; run(10);
    ENABLE = 1'b1; run(20);
    check("t5_gated_valid", n_valid, 32'd0);
    BTN = 4'b0000; run(12);
    BTN = 4'b0100; run(12);
    check("t5_fresh_valid", n_valid, 32'd1);
    check("t5_fresh_in", {30'd0, last_in}, 32'd2);
    BTN = 4'b0000;
    run(12);

    // Reset mid-debounce with colour 0 held
    clear_counts();
    BTN = 4'b0001; run(3);
    RST_N = 1'b0;
    #1;
    check("t6_rst_in", {30'd0, IN}, 32'd0);
    check("t6_rst_valid", {31'd0, IN_VALID}, 32'd0);
    check("t6_rst_err", {31'd0, MULTI_ERR}, 32'd0);
    check("t6_rst_stable", {28'd0, BTN_STABLE}, 32'h0);
    prev_in = 2'd0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    run(30);
    check("t6_held_valid", n_valid, 32'd0);
    check("t6_held_stable", {28'd0, BTN_STABLE}, 32'h1);
    BTN = 4'b0000; run(12);
    BTN = 4'b0001; run(12);
    check("t6_repress_valid", n_valid, 32'd1);
    check("t6_repress_in", {30'd0, last_in}, 32'd0);
    check("t6_err_none", n_err, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
